// File: rtl/uart_frame_loader.sv
// uart_frame_loader
//   Front-end between uart_rx and the CNN input feature buffer. Parses framed
//   pixel packets from the UART byte stream (SYNC byte, NPIX pixel bytes,
//   optional checksum) and writes each pixel as fixed point into ifmap storage.
//
//   Optional feature macro: FRAME_CHECKSUM_EN
//     defined   -> a trailing 8-bit checksum byte (sum of pixels mod 256) is
//                  mandatory; a mismatch aborts the frame with err_code=2.
//     undefined -> frame completes on the last pixel; no checksum logic.
//
// Ports
//   clk           system clock
//   reset         synchronous, active-low reset
//   rx_dv         1-cycle strobe, rx_byte valid
//   rx_byte       received byte
//   pipe_busy     CNN pipeline busy; a new frame is refused while high
//   wr_en         pixel write strobe
//   wr_addr       flat row-major pixel index
//   wr_data       rx_byte zero-extended and shifted left by FRAC_BITS
//   frame_loaded  1-cycle pulse, valid frame fully written
//   frame_error   1-cycle pulse, frame aborted
//   err_code      0 none, 1 timeout, 2 checksum, 3 overrun (held)
//   loading       high while a frame is being received
module uart_frame_loader #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned FRAC_BITS    = 7,
  parameter int unsigned IMG_SIZE     = 28,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 1000000,
  localparam int unsigned NPIX        = IMG_SIZE * IMG_SIZE,
  localparam int unsigned ADDR_W      = (NPIX > 1) ? $clog2(NPIX) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_dv,
  input  logic [7:0]            rx_byte,
  input  logic                  pipe_busy,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  frame_loaded,
  output logic                  frame_error,
  output logic [1:0]            err_code,
  output logic                  loading
);

  // Timer only ever has to reach TIMEOUT_CLKS-1.
  localparam int unsigned TW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;

`ifdef FRAME_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_PIX, S_CSUM} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_PIX} state_t;
`endif

  typedef enum logic [1:0] {ERR_NONE, ERR_TIMEOUT, ERR_CSUM, ERR_OVERRUN} err_t;

  state_t                state_q;
  logic [ADDR_W-1:0]     cnt_q;
  logic [TW-1:0]         timer_q;
  logic                  wr_en_q;
  logic [ADDR_W-1:0]     wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  frame_loaded_q;
  logic                  frame_error_q;
  err_t                  err_code_q;
  logic                  loading_q;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]            sum_q;
`endif

  logic [DATA_WIDTH-1:0] pix_fx;
  logic                  timeout_hit;

  assign pix_fx      = DATA_WIDTH'(rx_byte) << FRAC_BITS;
  assign timeout_hit = (TIMEOUT_CLKS != 0) && (timer_q == TW'(TIMEOUT_CLKS - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      timer_q        <= '0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      frame_loaded_q <= 1'b0;
      frame_error_q  <= 1'b0;
      err_code_q     <= ERR_NONE;
      loading_q      <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      sum_q          <= '0;
`endif
    end else begin
      wr_en_q        <= 1'b0;
      frame_loaded_q <= 1'b0;
      frame_error_q  <= 1'b0;

      // Idle-gap timer: cleared by every byte, frozen at zero outside a frame,
      // saturating so a disabled timeout can never wrap.
      if (state_q == S_IDLE || rx_dv) begin
        timer_q <= '0;
      end else if (timer_q != '1) begin
        timer_q <= timer_q + TW'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (rx_dv && rx_byte == SYNC_BYTE) begin
            if (pipe_busy) begin
              frame_error_q <= 1'b1;
              err_code_q    <= ERR_OVERRUN;
            end else begin
              state_q   <= S_PIX;
              loading_q <= 1'b1;
              cnt_q     <= '0;
`ifdef FRAME_CHECKSUM_EN
              sum_q     <= '0;
`endif
            end
          end
        end

        S_PIX: begin
          // Any byte value is pixel data here, including SYNC_BYTE.
          if (rx_dv) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= cnt_q;
            wr_data_q <= pix_fx;
            cnt_q     <= cnt_q + ADDR_W'(1);
`ifdef FRAME_CHECKSUM_EN
            sum_q     <= sum_q + rx_byte;
`endif
            if (cnt_q == ADDR_W'(NPIX - 1)) begin
`ifdef FRAME_CHECKSUM_EN
              state_q        <= S_CSUM;
`else
              state_q        <= S_IDLE;
              loading_q      <= 1'b0;
              frame_loaded_q <= 1'b1;
              err_code_q     <= ERR_NONE;
`endif
            end
          end else if (timeout_hit) begin
            state_q       <= S_IDLE;
            loading_q     <= 1'b0;
            frame_error_q <= 1'b1;
            err_code_q    <= ERR_TIMEOUT;
          end
        end

`ifdef FRAME_CHECKSUM_EN
        S_CSUM: begin
          if (rx_dv) begin
            state_q   <= S_IDLE;
            loading_q <= 1'b0;
            if (rx_byte == sum_q) begin
              frame_loaded_q <= 1'b1;
              err_code_q     <= ERR_NONE;
            end else begin
              frame_error_q <= 1'b1;
              err_code_q    <= ERR_CSUM;
            end
          end else if (timeout_hit) begin
            state_q       <= S_IDLE;
            loading_q     <= 1'b0;
            frame_error_q <= 1'b1;
            err_code_q    <= ERR_TIMEOUT;
          end
        end
`endif

        default: begin
          state_q   <= S_IDLE;
          loading_q <= 1'b0;
        end
      endcase
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign frame_loaded = frame_loaded_q;
  assign frame_error  = frame_error_q;
  assign err_code     = err_code_q;
  assign loading      = loading_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// tb_uart_frame_loader
//   Drives uart_frame_loader (IMG_SIZE=4, TIMEOUT_CLKS=100, FRAC_BITS=7) with
//   directed and randomized byte streams. A frame-level reference model turns
//   each driven cycle into expected output events on a queue; an independent
//   monitor pops and compares whenever the DUT raises an output strobe.
//   Builds with or without FRAME_CHECKSUM_EN, matching the DUT build.
module tb_uart_frame_loader;

  localparam int NPIX    = 16;
  localparam int TIMEOUT = 100;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        pipe_busy = 1'b0;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        frame_loaded;
  logic        frame_error;
  logic [1:0]  err_code;
  logic        loading;

  uart_frame_loader #(
    .DATA_WIDTH  (16),
    .FRAC_BITS   (7),
    .IMG_SIZE    (4),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CLKS(100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_dv       (rx_dv),
    .rx_byte     (rx_byte),
    .pipe_busy   (pipe_busy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_loaded(frame_loaded),
    .frame_error (frame_error),
    .err_code    (err_code),
    .loading     (loading)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  // kind: 0 pixel write, 1 frame_loaded, 2 frame_error
  typedef struct {
    int kind;
    int addr;
    int data;
    int code;
    int cyc;
  } ev_t;
  ev_t exp_q[$];

  // Reference model state (frame level)
  bit       in_frame = 0;
  int       px[$];
  int       last_edge = 0;
  int       exp_err = 0;
  int       reset_edge = -1;
  bit       busy_sel = 0;

  function automatic void push_ev(int kind, int addr, int data, int code, int c);
    ev_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.code = code; e.cyc = c;
    exp_q.push_back(e);
  endfunction

  function automatic int pix_sum();
    int s = 0;
    foreach (px[i]) s += px[i];
    return s % 256;
  endfunction

  // Expected behaviour for the edge numbered e, given what is driven for it.
  function automatic void model_cycle(bit rst_n, bit dv, int b, bit busy, int e);
    if (!rst_n) begin
      in_frame = 0; exp_err = 0; px.delete(); reset_edge = e;
      return;
    end
    if (in_frame && !dv && (e - last_edge) == TIMEOUT) begin
      push_ev(2, 0, 0, 1, e); exp_err = 1; in_frame = 0;
      return;
    end
    if (!dv) return;
    if (!in_frame) begin
      if (b == SYNC) begin
        if (busy) begin
          push_ev(2, 0, 0, 3, e); exp_err = 3;
        end else begin
          in_frame = 1; px.delete(); last_edge = e;
        end
      end
    end else if (px.size() < NPIX) begin
      push_ev(0, px.size(), b * 128, 0, e);
      px.push_back(b);
      last_edge = e;
`ifndef FRAME_CHECKSUM_EN
      if (px.size() == NPIX) begin
        push_ev(1, 0, 0, 0, e); exp_err = 0; in_frame = 0;
      end
`endif
    end else begin
      if (b == pix_sum()) begin
        push_ev(1, 0, 0, 0, e); exp_err = 0;
      end else begin
        push_ev(2, 0, 0, 2, e); exp_err = 2;
      end
      in_frame = 0;
    end
  endfunction

  // ---------------- driver ----------------
  task automatic tick(input bit rst_n, input bit dv, input int b);
    @(negedge clk); #1;
    reset     = rst_n;
    rx_dv     = dv;
    rx_byte   = b[7:0];
    // mid-frame pipe_busy is randomized; it must have no effect
    pipe_busy = in_frame ? 1'($urandom_range(0, 1)) : busy_sel;
    model_cycle(rst_n, dv, b & 8'hFF, pipe_busy, cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1, 0, $urandom_range(0, 255));
  endtask

  task automatic send(input int b);
    idle($urandom_range(0, 2));
    tick(1, 1, b);
  endtask

  task automatic send_good_frame();
    int s = 0;
    send(SYNC);
    for (int i = 0; i < NPIX; i++) begin
      int p = $urandom_range(0, 255);
      s += p;
      send(p);
    end
`ifdef FRAME_CHECKSUM_EN
    send(s % 256);
`endif
    idle(2);
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic take(input int kind);
    ev_t e;
    if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
      n_chk++; n_fail++;
      $display("FAIL unexpected_output: got kind %0d expected none (cycle %0d)", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      if (e.kind == 0 && kind == 0) begin
        chk("wr_addr", wr_addr, e.addr);
        chk("wr_data", wr_data, e.data);
      end
      if (kind != 0) chk("err_code_evt", err_code, e.code);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (wr_en === 1'b1)        take(0);
      if (frame_loaded === 1'b1) take(1);
      if (frame_error === 1'b1)  take(2);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        n_chk++; n_fail++;
        $display("FAIL missed_event: got none expected kind %0d at cycle %0d (now %0d)",
                 exp_q[0].kind, exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
      chk("loading", loading, in_frame);
      chk("err_code", err_code, exp_err);
      if (cyc == reset_edge) begin
        chk("rst_wr_en", wr_en, 0);
        chk("rst_loaded", frame_loaded, 0);
        chk("rst_error", frame_error, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    tick(0, 0, 0);
    tick(0, 0, 0);
    idle(3);

    // 1: counting frame, checksum 0x78
    send(SYNC);
    for (int i = 0; i < NPIX; i++) send(i);
`ifdef FRAME_CHECKSUM_EN
    send(8'h78);
    idle(3);
    // 2: same frame, bad checksum 0x79
    send(SYNC);
    for (int i = 0; i < NPIX; i++) send(i);
    send(8'h79);
`endif
    idle(3);

    // 3: five pixels then silence -> timeout after exactly TIMEOUT cycles
    send(SYNC);
    for (int i = 0; i < 5; i++) send(8'h30 + i);
    idle(TIMEOUT + 5);
    send_good_frame();

    // byte arriving in the expiry cycle is accepted
    send(SYNC);
    send(8'h11);
    idle(TIMEOUT - 1);
    tick(1, 1, 8'h22);
    for (int i = 2; i < NPIX; i++) send(i);
`ifdef FRAME_CHECKSUM_EN
    send((8'h11 + 8'h22 + 119) % 256);
`endif
    idle(3);

    // 4: header refused while busy, following byte ignored
    busy_sel = 1;
    send(SYNC);
    send(8'h10);
    busy_sel = 0;
    idle(2);
    send_good_frame();

    // 5: leading garbage, SYNC value as pixel data
    send(8'h00);
    send(8'hFF);
    send(SYNC);
    send(8'hFF);
    send(8'hA5);
    for (int i = 0; i < 14; i++) send(8'h01);
`ifdef FRAME_CHECKSUM_EN
    send(8'hB2);
`endif
    idle(3);

    // 6: reset mid-frame, then a full frame from address 0
    send(SYNC);
    for (int i = 0; i < 8; i++) send(8'h40 + i);
    tick(0, 0, 0);
    idle(2);
    send_good_frame();

    // randomized frames
    for (int f = 0; f < 12; f++) begin
      int mode;
      int s = 0;
      repeat ($urandom_range(0, 2)) begin
        int g = $urandom_range(0, 255);
        if (g == SYNC) g = 0;
        send(g);
      end
      busy_sel = ($urandom_range(0, 5) == 0);
      send(SYNC);
      if (busy_sel) begin
        busy_sel = 0;
        idle(2);
        continue;
      end
      mode = $urandom_range(0, 4);
      if (mode == 0) begin
        repeat ($urandom_range(1, NPIX - 1)) send($urandom_range(0, 255));
        idle(TIMEOUT + 3);
      end else begin
        for (int i = 0; i < NPIX; i++) begin
          int p = $urandom_range(0, 255);
          s += p;
          send(p);
        end
`ifdef FRAME_CHECKSUM_EN
        send((mode == 1) ? ((s % 256) ^ 8'h01) : (s % 256));
`endif
        idle(2);
      end
    end

    idle(5);
    if (exp_q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL pending_events: got %0d left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
